// File: rtl/gate_arbiter.sv
// gate_arbiter: round-robin sharing of one external gate datapath between NUM_REQ requesters,
// with registered gate drive and a single id-tagged valid/ready response channel.
module gate_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [NUM_REQ-1:0] req_a,
    input  logic [NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0] req_c,
    input  logic [NUM_REQ-1:0] req_d,
    output logic               g_a,
    output logic               g_b,
    output logic               g_c,
    output logic               g_d,
    input  logic               g_x,
    input  logic               g_y,
    input  logic               g_w,
    input  logic               g_u,
    input  logic               g_v,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [4:0]         rsp_data,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
    state_t state, state_nxt;
    logic [ID_W-1:0] ptr, gnt;
    logic found, hs_req;
    // Scan offsets from the far end so the one nearest ptr wins.
    always_comb begin
        int idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                gnt   = ID_W'(idx);
                found = 1'b1;
            end
        end
    end
    assign hs_req    = (state == IDLE) && found;
    assign req_ready = hs_req ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt : '0;
    assign busy      = (state != IDLE);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = found ? DRIVE : IDLE;
            DRIVE:   state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            g_a       <= 1'b0;
            g_b       <= 1'b0;
            g_c       <= 1'b0;
            g_d       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            state <= state_nxt;
            if (hs_req) begin
                g_a    <= req_a[gnt];
                g_b    <= req_b[gnt];
                g_c    <= req_c[gnt];
                g_d    <= req_d[gnt];
                rsp_id <= gnt;
                ptr    <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);
            end
            if (state == DRIVE) begin
                rsp_data  <= {g_v, g_u, g_w, g_y, g_x};
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end
endmodule
